// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch-to-decode bus widths, reset PC and branch bundle layout
package fetch_stage_pkg;
  localparam int FS2DS_BUS_LEN = 65;
  localparam int BR_ZIP_LEN = 33;
  localparam logic [31:0] RESET_PC = 32'h1bff_fffc;
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_zip_t;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with nextpc select, one-entry inst buffer and optional FS_ADEF_EN misalignment fault
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ds_allowin,
  output logic                     fs2ds_valid,
  output logic [FS2DS_BUS_LEN-1:0] fs2ds_bus,
  input  logic [BR_ZIP_LEN-1:0]    br_zip,
  input  logic                     wb_ex,
  input  logic                     ertn_flush,
  input  logic [31:0]              ex_entry,
  input  logic [31:0]              ertn_era,
  output logic                     inst_sram_en,
  output logic [3:0]               inst_sram_we,
  output logic [31:0]              inst_sram_addr,
  output logic [31:0]              inst_sram_wdata,
  input  logic [31:0]              inst_sram_rdata
);
  br_zip_t br;
  logic flush, fs_allowin, req, misalign, fs_adef, handshake, latch;
  logic [31:0] nextpc, fs_inst;
  logic fs_valid_q, fs_valid_d, buf_valid_q, buf_valid_d, fresh_q, fresh_d;
  logic [31:0] fs_pc_q, fs_pc_d, inst_buf_q, inst_buf_d;
  assign br = br_zip;
  always_comb begin
    flush = wb_ex | ertn_flush | br.taken;
    fs_allowin = ~fs_valid_q | ds_allowin | flush;
    nextpc = wb_ex ? ex_entry : ertn_flush ? ertn_era : br.taken ? br.target : fs_pc_q + 32'd4;
    req = fs_allowin & ~reset;
`ifdef FS_ADEF_EN
    misalign = |nextpc[1:0];
    fs_adef = |fs_pc_q[1:0];
`else
    misalign = 1'b0;
    fs_adef = 1'b0;
`endif
    inst_sram_en = req & ~misalign;
    inst_sram_we = 4'b0;
    inst_sram_addr = nextpc;
    inst_sram_wdata = 32'b0;
    fs2ds_valid = fs_valid_q & ~flush;
    handshake = fs2ds_valid & ds_allowin;
    fs_inst = fs_adef ? 32'h0 : buf_valid_q ? inst_buf_q : inst_sram_rdata;
    fs2ds_bus = {fs_adef, fs_pc_q, fs_inst};
    latch = fs_valid_q & fresh_q & ~ds_allowin & ~flush;
    fs_valid_d = req ? 1'b1 : (handshake | flush) ? 1'b0 : fs_valid_q;
    fs_pc_d = req ? nextpc : fs_pc_q;
    buf_valid_d = (handshake | flush) ? 1'b0 : latch ? 1'b1 : buf_valid_q;
    inst_buf_d = latch ? inst_sram_rdata : inst_buf_q;
    fresh_d = inst_sram_en;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q <= 1'b0;
      buf_valid_q <= 1'b0;
      fresh_q <= 1'b0;
      fs_pc_q <= RESET_PC;
      inst_buf_q <= 32'h0;
    end else begin
      fs_valid_q <= fs_valid_d;
      buf_valid_q <= buf_valid_d;
      fresh_q <= fresh_d;
      fs_pc_q <= fs_pc_d;
      inst_buf_q <= inst_buf_d;
    end
  end
endmodule
